noise_lfsr_q15: RTL
===================

NOISE_LFSR_Q15 -- requirements
Module: noise_lfsr_q15

Interface
REQ-001 Parameter SCALE_SHIFT, default 0: arithmetic right-shift applied to both raw noise words (0..15).
REQ-002 Parameter MAX_SAMPLES_W, default 8: width of num_samples and the transfer counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
REQ-006 num_samples  input  MAX_SAMPLES_W  burst length, sampled when start is accepted.
REQ-007 seed_load  input  1  loads seed into the LFSR; honoured only in IDLE.
REQ-008 seed  input  32  LFSR seed value.
REQ-009 noise_valid  output  1  noise_0/noise_1 hold a valid sample.
REQ-010 noise_ready  input  1  downstream generator accepts the sample.
REQ-011 noise_0  output  16  latent component 0, signed Q1.15.
REQ-012 noise_1  output  16  latent component 1, signed Q1.15.
REQ-013 busy  output  1  high in GEN and DONE.
REQ-014 done  output  1  one-cycle pulse at the end of a burst.

Function
REQ-015 The LFSR SHALL be a 32-bit Galois register, polynomial 0x80200003, advanced 16 bit-steps per update.
REQ-016 Sample mapping SHALL be: noise_0 = state[31:16] >>> SCALE_SHIFT, noise_1 = state[15:0] >>> SCALE_SHIFT, both sign-preserving.
REQ-017 The FSM SHALL have three states: IDLE, GEN and DONE.
REQ-018 IDLE transitions on accepted start: to GEN if num_samples != 0; to DONE if num_samples == 0.
REQ-019 GEN transitions to DONE on the transfer that makes count equal num_samples.
REQ-020 DONE SHALL last one cycle with done=1, then transition to IDLE.
REQ-021 Latency: when start is accepted at edge t, the LFSR SHALL advance once and noise_valid SHALL be high from t+1 with the sample from the advanced state.
REQ-022 Transfer occurs when noise_valid and noise_ready are both high at an edge.
REQ-023 While noise_valid is high and noise_ready is low, noise_0/noise_1 SHALL hold stable.
REQ-024 On a non-final transfer, the LFSR SHALL advance and the next sample SHALL present in the following cycle, giving 1 sample/cycle under continuous ready.
REQ-025 On the final transfer, noise_valid SHALL drop at the next edge and the LFSR SHALL NOT advance.
REQ-026 noise_valid SHALL never be high outside GEN.
REQ-027 start while busy SHALL be ignored; seed_load while busy SHALL be ignored.
REQ-028 A seed of 0 SHALL load DEFAULT_SEED (0xACE12468), avoiding lock-up.
REQ-029 When seed_load and start arrive together in IDLE, the seed SHALL load first and the first sample SHALL be advance(seed).
REQ-030 The transfer counter SHALL saturate-compare only and never wrap; num_samples of all-ones is legal.

Reset
REQ-031 While rst is high: LFSR=DEFAULT_SEED, state=IDLE, count=0, noise_valid=0, done=0, busy=0, noise_0=noise_1=0.
REQ-032 rst asserted mid-burst SHALL abort the burst with no done pulse; outputs take reset values at that edge.

Configuration
REQ-033 When NOISE_CLAMP_EN is defined, any shifted noise word equal to 0x8000 SHALL output 0x8001, giving a symmetric range of ±32767.
REQ-034 When NOISE_CLAMP_EN is undefined, 0x8000 SHALL pass unchanged.

Structure
REQ-035 Package noise_q15_pkg SHALL hold LFSR_POLY, DEFAULT_SEED, the FSM state type and the advance16 function.
REQ-036 One sub-module, lfsr32_step16, SHALL hold the 32-bit state register with load and advance enables.
REQ-037 The FSM, counter and handshake SHALL live in noise_lfsr_q15.

Verification
REQ-038 Reset: after rst is released, check LFSR=0xACE12468, noise_valid=0, busy=0, and that seed_load with seed=0 leaves 0xACE12468.
REQ-039 Burst: seed=0x00000001, num_samples=4, ready held 1 -> 4 consecutive transfers matching the model advance16 sequence, done high exactly one cycle after the 4th transfer.
REQ-040 Backpressure: ready low for 3 cycles mid-burst -> noise_0/noise_1 and noise_valid stable, with no LFSR advance and no lost or duplicated sample.
REQ-041 Zero length: start with num_samples=0 -> noise_valid never high, done high at t+1, IDLE at t+2.
REQ-042 Mid-burst: rst at 2nd sample -> IDLE, no done pulse; start issued during the burst -> ignored, count unaffected.
REQ-043 Clamp: with a model-chosen seed giving raw noise_0=0x8000 -> output 0x8001 with NOISE_CLAMP_EN defined and 0x8000 without it.

Source files
------------

// File: rtl/noise_q15_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noise_q15_pkg
// Purpose  : Shared constants, FSM state type and LFSR helper for the Q1.15
//            latent-noise generator.
// Contents : LFSR_POLY     - Galois feedback mask (right-shifting form)
//            DEFAULT_SEED  - reset / zero-seed substitute value
//            state_t       - IDLE / GEN / DONE burst states
//            advance16()   - sixteen Galois bit-steps in one call
// Revision : 1.0 - initial release
// ============================================================================
package noise_q15_pkg;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Right-shifting Galois step: the bit shifted out of bit 0 decides whether
  // the feedback mask is folded back in. Sixteen steps produce one fresh
  // 16-bit chunk per update.
  function automatic logic [31:0] advance16(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 16; i++) begin
      r = {1'b0, r[31:1]} ^ (r[0] ? LFSR_POLY : 32'h0000_0000);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr32_step16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr32_step16
// Purpose  : 32-bit Galois LFSR state register with load and advance enables.
//            A load and an advance in the same cycle load first, then
//            advance the loaded value. A zero load value is replaced with
//            DEFAULT_SEED so the register can never lock up at all-zeros.
// Ports    : clk        - clock
//            rst        - synchronous active-high reset (state = DEFAULT_SEED)
//            load_en    - load load_value this cycle
//            load_value - seed to load
//            adv_en     - advance by 16 bit-steps this cycle
//            state_next - value the register takes at the next edge
// Revision : 1.0 - initial release
// ============================================================================
module lfsr32_step16
  import noise_q15_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_value,
  input  logic        adv_en,
  output logic [31:0] state_next
);

  logic [31:0] state_q;
  logic [31:0] state_d;
  logic [31:0] base;

  always_comb begin
    base = state_q;
    if (load_en) begin
      base = (load_value == 32'h0000_0000) ? DEFAULT_SEED : load_value;
    end
    state_d = adv_en ? advance16(base) : base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEFAULT_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_next = state_d;

endmodule
`default_nettype wire

// File: rtl/noise_lfsr_q15.sv
`default_nettype none
// ============================================================================
// Module   : noise_lfsr_q15
// Purpose  : Burst generator of paired signed Q1.15 latent-noise samples from
//            a 32-bit Galois LFSR, with valid/ready handshake.
// Params   : SCALE_SHIFT   - arithmetic right shift applied to both words
//            MAX_SAMPLES_W - width of num_samples and the transfer counter
// Macro    : NOISE_CLAMP_EN - when defined, a shifted word of 0x8000 is
//            output as 0x8001 (symmetric +/-32767 range)
// Ports    : clk, rst (sync, active-high)
//            start, num_samples       - burst request (IDLE only)
//            seed_load, seed          - LFSR seed load (IDLE only)
//            noise_valid/noise_ready  - output handshake
//            noise_0, noise_1         - Q1.15 sample pair
//            busy                     - high in GEN and DONE
//            done                     - one-cycle end-of-burst pulse
// Revision : 1.0 - initial release
// ============================================================================
module noise_lfsr_q15
  import noise_q15_pkg::*;
#(
  parameter int SCALE_SHIFT   = 0,
  parameter int MAX_SAMPLES_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [MAX_SAMPLES_W-1:0] num_samples,
  input  logic                     seed_load,
  input  logic [31:0]              seed,
  output logic                     noise_valid,
  input  logic                     noise_ready,
  output logic [15:0]              noise_0,
  output logic [15:0]              noise_1,
  output logic                     busy,
  output logic                     done
);

  state_t                   state_q, state_d;
  logic [MAX_SAMPLES_W-1:0] count_q, count_d;
  logic [MAX_SAMPLES_W-1:0] num_q, num_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [15:0]              noise_0_q, noise_0_d;
  logic [15:0]              noise_1_q, noise_1_d;

  logic                     lfsr_load;
  logic                     lfsr_adv;
  logic [31:0]              lfsr_next;
  logic                     xfer;
  logic [MAX_SAMPLES_W:0]   count_inc;
  logic                     last_xfer;

  lfsr32_step16 u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load_en    (lfsr_load),
    .load_value (seed),
    .adv_en     (lfsr_adv),
    .state_next (lfsr_next)
  );

  // Sign-preserving scale, then optional removal of the lone -1.0 code.
  function automatic logic [15:0] map_word(input logic [15:0] w);
    logic [15:0] sh;
    sh = 16'($signed(w) >>> SCALE_SHIFT);
`ifdef NOISE_CLAMP_EN
    if (sh == 16'h8000) begin
      sh = 16'h8001;
    end
`endif
    return sh;
  endfunction

  assign xfer = valid_q & noise_ready;

  // One bit wider than the counter so the final-transfer compare stays
  // exact even when num_samples is all-ones; the counter itself never wraps.
  assign count_inc = {1'b0, count_q} + {{MAX_SAMPLES_W{1'b0}}, 1'b1};
  assign last_xfer = (count_inc == {1'b0, num_q});

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    num_d     = num_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lfsr_load = seed_load;
        if (start) begin
          num_d   = num_samples;
          count_d = '0;
          busy_d  = 1'b1;
          if (num_samples != '0) begin
            // First sample comes from the freshly advanced state (which
            // includes a seed loaded in this same cycle).
            state_d  = ST_GEN;
            valid_d  = 1'b1;
            lfsr_adv = 1'b1;
          end else begin
            // Empty burst: no sample is produced, so the LFSR is left alone.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_GEN: begin
        if (xfer) begin
          count_d = count_inc[MAX_SAMPLES_W-1:0];
          if (last_xfer) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            lfsr_adv = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output words only change when the LFSR advances, which keeps them
  // stable under backpressure and after the final transfer.
  always_comb begin
    noise_0_d = noise_0_q;
    noise_1_d = noise_1_q;
    if (lfsr_adv) begin
      noise_0_d = map_word(lfsr_next[31:16]);
      noise_1_d = map_word(lfsr_next[15:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      num_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      noise_0_q <= 16'h0000;
      noise_1_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      num_q     <= num_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      noise_0_q <= noise_0_d;
      noise_1_q <= noise_1_d;
    end
  end

  assign noise_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign noise_0     = noise_0_q;
  assign noise_1     = noise_1_q;

endmodule
`default_nettype wire
